mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/llsc_link.sv | 41 ++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, machine word and memory arbiter states.
// Contents:
//   word_t       32-bit machine word
//   ramstate_t   RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t  mem_arbiter FSM states (IDLE/IGNT/DGNT/SCFAIL)
//   SC_OK/SC_FAIL  values returned on dload for a store-conditional
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGNT   = 2'd1,
        DGNT   = 2'd2,
        SCFAIL = 2'd3
    } arb_state_t;

    localparam word_t SC_OK   = 32'd1;
    localparam word_t SC_FAIL = 32'd0;

endpackage

// File: rtl/llsc_link.sv
// Load-linked / store-conditional link register.
// Holds a valid bit and the linked address; set by LL completion, cleared by a
// successful SC or by a plain store to the linked address.
// Ports:
//   CLK       clock, rising edge
//   nRST      synchronous active-low reset
//   ll_done   LL completed this cycle (link addr)
//   sc_done   SC completed this cycle (drop the link)
//   sw_done   non-atomic store completed this cycle
//   addr      current data address
//   match     link valid and linked address equals addr
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ll_done,
    input  logic  sc_done,
    input  logic  sw_done,
    input  word_t addr,
    output logic  match
);

    logic  valid_q;
    word_t addr_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (ll_done) begin
            valid_q <= 1'b1;
            addr_q  <= addr;
        end else if (sc_done || (sw_done && (addr == addr_q))) begin
            valid_q <= 1'b0;
        end
    end

    assign match = valid_q && (addr == addr_q);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (instruction fetch / data) in front of a single
// RAM port, with LL/SC support and a per-transaction wait limit.
// Ports:
//   CLK, nRST               clock and synchronous active-low reset
//   iREN, iaddr             fetch request and address
//   iload, ihit             fetched word and fetch-complete pulse
//   dREN, dWEN, datomic     data read / write request; datomic makes them LL / SC
//   daddr, dstore           data address and store data
//   dload, dhit             load data (or SC flag) and data-complete pulse
//   ramREN, ramWEN          RAM strobes
//   ramaddr, ramstore       RAM address and write data
//   ramload, ramstate       RAM read data and handshake state
//   merr                    sticky memory-error flag
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAXWAIT = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      ihit,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      datomic,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dhit,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      merr
);

    localparam int unsigned WaitW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

    arb_state_t       state_q, state_d;
    logic             last_d_q;      // 1: last hit served the data side
    logic [WaitW-1:0] wait_q;
    logic             merr_q;
    logic             op_write_q;    // data op kind, frozen at grant time
    logic             op_atomic_q;

    logic  d_req, d_write, sc_req, access, timeout, fault, link_match;
    logic  abort, hit_i, hit_d, ram_ren, ram_wen;
    word_t load_i, load_d, ram_addr, ram_store;
    logic  ll_done, sc_done, sw_done;

    // Both strobes high is treated as a read.
    assign d_req   = dREN || dWEN;
    assign d_write = dWEN && !dREN;
    assign sc_req  = datomic && d_write;
    assign access  = (ramstate == ACCESS);
    // Abort on the cycle that would make the MAXWAIT-th non-ACCESS grant cycle.
    assign timeout = (32'(wait_q) + 32'd1) >= MAXWAIT;
    assign fault   = (ramstate == ERROR) || (!access && timeout);

    always_comb begin
        state_d   = state_q;
        abort     = 1'b0;
        hit_i     = 1'b0;
        hit_d     = 1'b0;
        load_i    = '0;
        load_d    = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(last_d_q && iREN)) begin
                    state_d = (sc_req && !link_match) ? SCFAIL : DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr;
                if (access) begin
                    // A withdrawn fetch still completes, but silently.
                    hit_i   = iREN;
                    load_i  = iREN ? ramload : '0;
                    state_d = IDLE;
                end else if (fault) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            DGNT: begin
                ram_ren   = !op_write_q;
                ram_wen   = op_write_q;
                ram_addr  = daddr;
                ram_store = dstore;
                if (access) begin
                    hit_d = d_req;
                    if (d_req) begin
                        load_d = (op_write_q && op_atomic_q) ? SC_OK : ramload;
                    end
                    state_d = IDLE;
                end else if (fault) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            SCFAIL: begin
                hit_d   = 1'b1;
                load_d  = SC_FAIL;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            wait_q      <= '0;
            merr_q      <= 1'b0;
            op_write_q  <= 1'b0;
            op_atomic_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                wait_q      <= '0;
                op_write_q  <= d_write;
                op_atomic_q <= datomic;
            end else if ((state_q != SCFAIL) && !access && (32'(wait_q) < MAXWAIT)) begin
                wait_q <= wait_q + WaitW'(1);
            end
            if (abort) begin
                merr_q <= 1'b1;
            end
            if (hit_i) begin
                last_d_q <= 1'b0;
            end else if (hit_d) begin
                last_d_q <= 1'b1;
            end
        end
    end

    // Link updates follow the RAM access itself, even if the hit is suppressed.
    assign ll_done = (state_q == DGNT) && access && !op_write_q && op_atomic_q;
    assign sc_done = (state_q == DGNT) && access && op_write_q && op_atomic_q;
    assign sw_done = (state_q == DGNT) && access && op_write_q && !op_atomic_q;

    llsc_link u_link (
        .CLK     (CLK),
        .nRST    (nRST),
        .ll_done (ll_done),
        .sc_done (sc_done),
        .sw_done (sw_done),
        .addr    (daddr),
        .match   (link_match)
    );

    // All outputs are forced low while reset is held.
    assign ihit     = nRST && hit_i;
    assign dhit     = nRST && hit_d;
    assign iload    = nRST ? load_i : '0;
    assign dload    = nRST ? load_d : '0;
    assign ramREN   = nRST && ram_ren;
    assign ramWEN   = nRST && ram_wen;
    assign ramaddr  = nRST ? ram_addr : '0;
    assign ramstore = nRST ? ram_store : '0;
    assign merr     = nRST && merr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model of the grant
// rule, link register and error flag, compared against the DUT every cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned MaxW = 4;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, ihit, dREN, dWEN, datomic, dhit, ramREN, ramWEN, merr;
    word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    mem_arbiter #(.MAXWAIT(MaxW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .datomic  (datomic),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle
    logic  e_ramREN, e_ramWEN, e_ihit, e_dhit, e_merr;
    word_t e_ramaddr, e_ramstore, e_iload, e_dload;

    // Model state
    logic  m_last_d, m_lv, m_merr;
    word_t m_la;

    // Per-round observations
    int    obs_cyc, obs_hit_cyc, obs_ren_cnt;
    logic  obs_ihit, obs_dhit, obs_wen, obs_merr;
    word_t obs_iload, obs_dload;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ramREN",   32'(ramREN),   32'(e_ramREN));
            chk("ramWEN",   32'(ramWEN),   32'(e_ramWEN));
            chk("ramaddr",  ramaddr,       e_ramaddr);
            chk("ramstore", ramstore,      e_ramstore);
            chk("ihit",     32'(ihit),     32'(e_ihit));
            chk("iload",    iload,         e_iload);
            chk("dhit",     32'(dhit),     32'(e_dhit));
            chk("dload",    dload,         e_dload);
            chk("merr",     32'(merr),     32'(e_merr));
            chk("hit_excl", 32'(ihit && dhit), 32'd0);
        end
    end

    task automatic clear_exp();
        e_ramREN = 1'b0; e_ramWEN = 1'b0; e_ihit = 1'b0; e_dhit = 1'b0;
        e_ramaddr = '0; e_ramstore = '0; e_iload = '0; e_dload = '0;
        e_merr = m_merr;
    endtask

    task automatic obs_clear();
        obs_cyc = -1; obs_hit_cyc = -1; obs_ren_cnt = 0;
        obs_ihit = 1'b0; obs_dhit = 1'b0; obs_wen = 1'b0; obs_merr = 1'b0;
        obs_iload = '0; obs_dload = '0;
    endtask

    task automatic tick();
        @(negedge CLK);
        obs_cyc++;
        if (ramREN) obs_ren_cnt++;
        if (ramWEN) obs_wen = 1'b1;
        if (ihit) begin obs_ihit = 1'b1; obs_iload = iload; obs_hit_cyc = obs_cyc; end
        if (dhit) begin obs_dhit = 1'b1; obs_dload = dload; obs_hit_cyc = obs_cyc; end
        obs_merr = merr;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        nRST = 1'b0;
        m_merr = 1'b0;
        clear_exp();
        ramstate = ramstate_t'($urandom_range(0, 3));
        ramload = $urandom;
        repeat (n) tick();
        nRST = 1'b1;
        m_last_d = 1'b0; m_lv = 1'b0; m_la = '0; m_merr = 1'b0;
    endtask

    // One arbitration round: an IDLE decision cycle plus whatever it grants.
    // mode 0: ACCESS after lat non-ACCESS cycles; 1: ERROR after lat; 2: stuck.
    task automatic run_round(input logic ir, input word_t ia, input logic dr, input logic dw,
                             input logic da, input word_t dad, input word_t dst,
                             input int lat, input int mode, input logic drop,
                             input word_t acc_load);
        int        w;
        int        nacc;
        logic      is_wr, is_sc, hit;
        ramstate_t rs;
        obs_clear();
        is_wr = dw && !dr;
        is_sc = da && is_wr;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; datomic = da; daddr = dad; dstore = dst;
        ramstate = ramstate_t'($urandom_range(0, 3));
        ramload = $urandom;
        clear_exp();
        if ((dr || dw) && !(m_last_d && ir)) w = 2;
        else if (ir) w = 1;
        else w = 0;
        tick();
        if (w == 0) return;
        if (w == 2 && is_sc && !(m_lv && m_la == dad)) begin
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload = $urandom;
            clear_exp();
            e_dhit = 1'b1;
            tick();
            m_last_d = 1'b1;
            return;
        end
        nacc = 0;
        hit = 1'b0;
        for (int k = 0; k < 64; k++) begin
            clear_exp();
            ramload = $urandom;
            if (mode == 0 && k == lat) rs = ACCESS;
            else if (mode == 1 && k == lat) rs = ERROR;
            else rs = ramstate_t'($urandom_range(0, 1));
            ramstate = rs;
            if (w == 1) begin
                e_ramREN = 1'b1; e_ramaddr = ia;
            end else begin
                e_ramREN = !is_wr; e_ramWEN = is_wr; e_ramaddr = dad; e_ramstore = dst;
            end
            if (rs == ACCESS) begin
                ramload = acc_load;
                if (drop) begin
                    if (w == 1) iREN = 1'b0;
                    else begin dREN = 1'b0; dWEN = 1'b0; end
                end
                hit = !drop;
                if (w == 1) begin
                    e_ihit = hit; e_iload = hit ? acc_load : 32'd0;
                end else begin
                    e_dhit = hit; e_dload = hit ? (is_sc ? 32'd1 : acc_load) : 32'd0;
                end
            end
            tick();
            if (rs == ACCESS) begin
                if (hit) m_last_d = (w == 2);
                if (w == 2) begin
                    if (da && !is_wr) begin m_lv = 1'b1; m_la = dad; end
                    else if (is_sc) m_lv = 1'b0;
                    else if (is_wr && dad == m_la) m_lv = 1'b0;
                end
                return;
            end
            if (rs == ERROR) begin m_merr = 1'b1; return; end
            nacc++;
            if (nacc == int'(MaxW)) begin m_merr = 1'b1; return; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat;
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; datomic = 1'b0;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = '0; ramstate = FREE;
        m_merr = 1'b0;
        @(posedge CLK); #1;
        chk_en = 1'b1;
        do_reset(2);

        // Fetch only: two waits, then ACCESS
        run_round(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0, 1'b0, 32'h3C010005);
        chk("fetch_hit_cycle", 32'(obs_hit_cyc), 32'd3);
        chk("fetch_iload", obs_iload, 32'h3C010005);
        run_round(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
        chk("idle_ramREN", 32'(obs_ren_cnt), 32'd0);

        // Contention: D, I, D, I
        for (int r = 0; r < 4; r++) begin
            run_round(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1, 0, 1'b0, $urandom);
            pat = (r % 2 == 0) ? 2'b01 : 2'b10;
            chk("contention_order", 32'({obs_ihit, obs_dhit}), 32'(pat));
        end

        // LL/SC success, then repeated SC fails
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 1, 0, 1'b0, 32'hAAAA5555);
        run_round(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 32'd7, 0, 0, 1'b0, 32'h12345678);
        chk("sc_ok_wen", 32'(obs_wen), 32'd1);
        chk("sc_ok_dload", obs_dload, 32'd1);
        run_round(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 32'd7, 0, 0, 1'b0, 32'h12345678);
        chk("sc_again_dhit", 32'(obs_dhit), 32'd1);
        chk("sc_again_wen", 32'(obs_wen), 32'd0);
        chk("sc_again_dload", obs_dload, 32'd0);

        // Link break by a plain store
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 0, 0, 1'b0, 32'h1);
        run_round(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h9, 1, 0, 1'b0, 32'h2);
        run_round(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h7, 0, 0, 1'b0, 32'h3);
        chk("break_sc_wen", 32'(obs_wen), 32'd0);
        chk("break_sc_dload", obs_dload, 32'd0);

        // Timeout, then a good access with merr held
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0, 2, 1'b0, 32'h0);
        chk("timeout_no_dhit", 32'(obs_dhit), 32'd0);
        chk("timeout_ren_cycles", 32'(obs_ren_cnt), 32'd4);
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1, 0, 1'b0, 32'hBEEF);
        chk("after_timeout_dhit", 32'(obs_dhit), 32'd1);
        chk("after_timeout_dload", obs_dload, 32'hBEEF);
        chk("merr_held", 32'(obs_merr), 32'd1);

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            int    kind, sel, mode;
            logic  dr, dw, da;
            word_t dad;
            kind = $urandom_range(0, 5);
            da = 1'(($urandom & 1));
            unique case (kind)
                0: begin dr = 1'b0; dw = 1'b0; end
                1: begin dr = 1'b1; dw = 1'b0; da = 1'b0; end
                2: begin dr = 1'b0; dw = 1'b1; da = 1'b0; end
                3: begin dr = 1'b1; dw = 1'b0; da = 1'b1; end
                4: begin dr = 1'b0; dw = 1'b1; da = 1'b1; end
                default: begin dr = 1'b1; dw = 1'b1; end
            endcase
            sel = $urandom_range(0, 2);
            dad = 32'h200 + 32'(sel * 4);
            mode = $urandom_range(0, 19);
            mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
            run_round(1'(($urandom & 1)), $urandom, dr, dw, da, dad, $urandom,
                      $urandom_range(0, 3), mode, ($urandom_range(0, 9) == 0), $urandom);
        end

        // Reset in the middle of a data grant
        iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; datomic = 1'b1; daddr = 32'h300; dstore = 32'h5;
        ramstate = FREE;
        clear_exp();
        tick();
        clear_exp();
        e_ramREN = 1'b1; e_ramaddr = 32'h300; e_ramstore = 32'h5;
        ramstate = BUSY;
        tick();
        ramstate = ACCESS;
        do_reset(1);
        dREN = 1'b0; datomic = 1'b0;
        obs_clear();
        ramstate = FREE;
        clear_exp();
        tick();
        chk("merr_after_reset", 32'(obs_merr), 32'd0);
        run_round(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h7, 0, 0, 1'b0, 32'h1);
        chk("post_reset_sc_dhit", 32'(obs_dhit), 32'd1);
        chk("post_reset_sc_wen", 32'(obs_wen), 32'd0);
        chk("post_reset_sc_dload", obs_dload, 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
